// File: rtl/lotr_pkg.sv
`default_nettype none
// ============================================================================
// Package     : lotr_pkg
// Description : Shared board-level defaults for the input debounce block.
// Revision    : 1.0 - initial release
// ============================================================================
package lotr_pkg;

    localparam int c_DEF_NUM_CH    = 12;
    localparam int c_DEF_DB_CYCLES = 500000;

endpackage
`default_nettype wire

// File: rtl/io_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module      : io_debounce_ch
// Description : One input channel: 2-flop synchronizer, polarity correction,
//               debounce counter, stable level and single-cycle edge pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module io_debounce_ch
    import lotr_pkg::*;
#(
    parameter int DB_CYCLES = c_DEF_DB_CYCLES,
    parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    input  logic i_invert,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_rise;
    logic             r_fall;
    logic [CNT_W-1:0] r_cnt;

    logic             w_s;
    logic             w_diff;
    logic             w_done;

    // Inverting after the synchronizer makes a mask change look like an
    // ordinary input change, so it is debounced the same way.
    assign w_s    = r_sync2 ^ i_invert;
    assign w_diff = (w_s != r_stable);
    assign w_done = w_diff && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_rise  <= w_done &  w_s;
            r_fall  <= w_done & ~w_s;
            if (!w_diff || w_done) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_done) begin
                r_stable <= w_s;
            end
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;

endmodule
`default_nettype wire

// File: rtl/io_debounce_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : io_debounce_ctrl
// Description : Debounces NUM_CH board inputs and latches enabled edge events
//               into sticky bits that drive a single interrupt line.
// Revision    : 1.0 - initial release
// ============================================================================
module io_debounce_ctrl
    import lotr_pkg::*;
#(
    parameter int NUM_CH    = c_DEF_NUM_CH,
    parameter int DB_CYCLES = c_DEF_DB_CYCLES,
    parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
    input  logic              QClk,
    input  logic              RstQnnnH,
    input  logic [NUM_CH-1:0] RawIn,
    input  logic [NUM_CH-1:0] InvertMask,
    output logic [NUM_CH-1:0] Stable,
    output logic [NUM_CH-1:0] RiseEvt,
    output logic [NUM_CH-1:0] FallEvt,
    input  logic [NUM_CH-1:0] IrqMaskRise,
    input  logic [NUM_CH-1:0] IrqMaskFall,
    output logic [NUM_CH-1:0] EvtSticky,
    input  logic              ClrValid,
    input  logic [NUM_CH-1:0] ClrMask,
    output logic              IntPending
);

    logic [NUM_CH-1:0] r_sticky;
    logic [NUM_CH-1:0] w_set;
    logic [NUM_CH-1:0] w_clr;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            io_debounce_ch #(
                .DB_CYCLES (DB_CYCLES),
                .CNT_W     (CNT_W)
            ) u_ch (
                .clk      (QClk),
                .rst      (RstQnnnH),
                .i_raw    (RawIn[gi]),
                .i_invert (InvertMask[gi]),
                .o_stable (Stable[gi]),
                .o_rise   (RiseEvt[gi]),
                .o_fall   (FallEvt[gi])
            );
        end
    endgenerate

    assign w_set = (RiseEvt & IrqMaskRise) | (FallEvt & IrqMaskFall);
    assign w_clr = ClrMask & {NUM_CH{ClrValid}};

    // A new event arriving with a clear request keeps the bit set.
    always_ff @(posedge QClk) begin
        if (RstQnnnH) begin
            r_sticky <= '0;
        end else begin
            r_sticky <= (r_sticky & ~w_clr) | w_set;
        end
    end

    assign EvtSticky  = r_sticky;
    assign IntPending = |r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_io_debounce_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_debounce_ctrl
// Description : Directed and randomized self-checking bench for
//               io_debounce_ctrl against a windowed behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_debounce_ctrl;

    localparam int NCH = 12;
    localparam int DB  = 4;

    logic           QClk = 1'b0;
    logic           RstQnnnH;
    logic [NCH-1:0] RawIn, InvertMask, IrqMaskRise, IrqMaskFall, ClrMask;
    logic           ClrValid;
    logic [NCH-1:0] Stable, RiseEvt, FallEvt, EvtSticky;
    logic           IntPending;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: synchronizer delay line, recent S window per channel,
    // samples since last flip, and the observable outputs.
    logic [NCH-1:0] m_d1, m_d2, m_stab, m_rise, m_fall, m_sticky;
    logic [DB-1:0]  m_hist [NCH];
    int             m_since [NCH];

    io_debounce_ctrl #(
        .NUM_CH    (NCH),
        .DB_CYCLES (DB)
    ) dut (
        .QClk        (QClk),
        .RstQnnnH    (RstQnnnH),
        .RawIn       (RawIn),
        .InvertMask  (InvertMask),
        .Stable      (Stable),
        .RiseEvt     (RiseEvt),
        .FallEvt     (FallEvt),
        .IrqMaskRise (IrqMaskRise),
        .IrqMaskFall (IrqMaskFall),
        .EvtSticky   (EvtSticky),
        .ClrValid    (ClrValid),
        .ClrMask     (ClrMask),
        .IntPending  (IntPending)
    );

    always #5 QClk = ~QClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one rising edge using pre-edge inputs, clock the
    // DUT, then compare all outputs 1 time unit after the edge.
    task automatic tick();
        logic s;
        if (RstQnnnH) begin
            m_d1 = '0; m_d2 = '0; m_stab = '0; m_rise = '0; m_fall = '0; m_sticky = '0;
            for (int i = 0; i < NCH; i++) begin
                m_hist[i]  = '0;
                m_since[i] = 0;
            end
        end else begin
            m_sticky = (m_sticky & ~(ClrValid ? ClrMask : '0))
                     | (m_rise & IrqMaskRise) | (m_fall & IrqMaskFall);
            for (int i = 0; i < NCH; i++) begin
                s = m_d2[i] ^ InvertMask[i];
                m_hist[i] = {m_hist[i][DB-2:0], s};
                if (m_since[i] < DB) m_since[i]++;
                m_rise[i] = 1'b0;
                m_fall[i] = 1'b0;
                // Flip only after DB consecutive samples all disagree with Stable.
                if (m_since[i] >= DB && m_hist[i] == {DB{~m_stab[i]}}) begin
                    m_stab[i]  = s;
                    m_rise[i]  = s;
                    m_fall[i]  = ~s;
                    m_since[i] = 0;
                end
            end
            m_d2 = m_d1;
            m_d1 = RawIn;
        end
        @(posedge QClk);
        #1;
        chk("stable",  32'(Stable),     32'(m_stab));
        chk("rise",    32'(RiseEvt),    32'(m_rise));
        chk("fall",    32'(FallEvt),    32'(m_fall));
        chk("sticky",  32'(EvtSticky),  32'(m_sticky));
        chk("intpend", 32'(IntPending), 32'(|m_sticky));
    endtask

    initial begin
        RstQnnnH = 1'b1; RawIn = '0; InvertMask = '0; IrqMaskRise = '0;
        IrqMaskFall = '0; ClrValid = 1'b0; ClrMask = '0;

        // Quiet reset: nothing may move for 20 cycles.
        repeat (3) tick();
        chk("rst_stable", 32'(Stable), 32'd0);
        RstQnnnH = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("quiet_evt", 32'(RiseEvt | FallEvt), 32'd0);
            chk("quiet_irq", 32'(IntPending), 32'd0);
        end

        // Inverted channel 1 held high through reset reads as 0.
        InvertMask[1] = 1'b1; RawIn[1] = 1'b1; RstQnnnH = 1'b1;
        repeat (2) tick();
        RstQnnnH = 1'b0;
        repeat (10) tick();
        chk("inv_idle", 32'(Stable[1]), 32'd0);
        IrqMaskRise[1] = 1'b1; RawIn[1] = 1'b0;
        repeat (5) tick();
        chk("inv_e5", 32'(Stable[1]), 32'd0);
        tick();
        chk("inv_e6", 32'(Stable[1]), 32'd1);
        tick();
        chk("inv_sticky", 32'(EvtSticky[1]), 32'd1);

        // Channel 0 rise, clear of bits 0/1 coincides with the bit-0 set.
        IrqMaskRise[0] = 1'b1; RawIn[0] = 1'b1;
        repeat (5) tick();
        chk("ch0_e5", 32'(Stable[0]), 32'd0);
        tick();
        chk("ch0_e6_stable", 32'(Stable[0]), 32'd1);
        chk("ch0_e6_rise", 32'(RiseEvt[0]), 32'd1);
        ClrValid = 1'b1; ClrMask = 12'h003;
        tick();
        chk("clr_set_wins", 32'(EvtSticky[0]), 32'd1);
        chk("clr_bit1", 32'(EvtSticky[1]), 32'd0);
        chk("ch0_e7_irq", 32'(IntPending), 32'd1);
        chk("ch0_e7_rise", 32'(RiseEvt[0]), 32'd0);
        ClrValid = 1'b0; ClrMask = '0;
        tick();

        // Three-cycle glitch on channel 3 must be rejected.
        RawIn[3] = 1'b1;
        repeat (3) tick();
        RawIn[3] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("glitch", 32'({Stable[3], RiseEvt[3], FallEvt[3]}), 32'd0);
        end

        // Reset while channel 2 counter sits at DB-1.
        RawIn[2] = 1'b1;
        repeat (5) tick();
        RstQnnnH = 1'b1;
        tick();
        chk("midrst_stable", 32'(Stable), 32'd0);
        chk("midrst_sticky", 32'(EvtSticky), 32'd0);
        RstQnnnH = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("redb_wait", 32'({Stable[2], RiseEvt[2], FallEvt[2]}), 32'd0);
        end
        tick();
        chk("redb_stable", 32'(Stable[2]), 32'd1);
        chk("redb_rise", 32'(RiseEvt[2]), 32'd1);

        // Randomized traffic against the model.
        IrqMaskFall = 12'hFFF;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 3) == 0) RawIn[$urandom_range(0, NCH-1)] ^= 1'b1;
            if ($urandom_range(0, 39) == 0) InvertMask[$urandom_range(0, NCH-1)] ^= 1'b1;
            if (k % 50 == 0) begin
                IrqMaskRise = 12'($urandom);
                IrqMaskFall = 12'($urandom);
            end
            ClrValid = ($urandom_range(0, 7) == 0);
            ClrMask  = 12'($urandom);
            RstQnnnH = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
